// File: rtl/clk2_monitor.sv
// clk2_monitor: synchronises po's clk2/rr into clk, measures clk2
// period/high time, flags clk2 loss and counts rr rising edges.
module clk2_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk2,
  input  logic             rr,
  input  logic             rr_count_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             lost,
  output logic [CNT_W-1:0] rr_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT = '1;

  state_t state, state_nx;

  logic c2_s1, c2_s2, c2_s3;
  logic rr_s1, rr_s2, rr_s3;
  logic c2_rise, rr_rise, tmo;

  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] hi, hi_nx;
  logic [CNT_W-1:0] period_nx, high_nx, rr_nx;
  logic             lost_nx, valid_nx;

  assign c2_rise = c2_s2 & ~c2_s3;
  assign rr_rise = rr_s2 & ~rr_s3;
  assign tmo     = (cnt == TMO);

  always_ff @(posedge clk) begin
    if (rst) begin
      c2_s1 <= 1'b0;
      c2_s2 <= 1'b0;
      c2_s3 <= 1'b0;
      rr_s1 <= 1'b0;
      rr_s2 <= 1'b0;
      rr_s3 <= 1'b0;
    end else begin
      c2_s1 <= clk2;
      c2_s2 <= c2_s1;
      c2_s3 <= c2_s2;
      rr_s1 <= rr;
      rr_s2 <= rr_s1;
      rr_s3 <= rr_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      lost       <= 1'b0;
      rr_count   <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      hi         <= hi_nx;
      period     <= period_nx;
      high_time  <= high_nx;
      meas_valid <= valid_nx;
      lost       <= lost_nx;
      rr_count   <= rr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    hi_nx     = hi;
    period_nx = period;
    high_nx   = high_time;
    lost_nx   = lost;
    valid_nx  = 1'b0;
    if (!enable) begin
      // a pending measurement is dropped, never reported
      state_nx = IDLE;
      cnt_nx   = '0;
      hi_nx    = '0;
      lost_nx  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = ARM;
          cnt_nx   = '0;
          hi_nx    = '0;
        end
        ARM: begin
          if (c2_rise) begin
            state_nx = MEAS;
            cnt_nx   = ONE;
            hi_nx    = ONE;
          end else if (tmo) begin
            lost_nx = 1'b1;
            cnt_nx  = '0;
          end else begin
            cnt_nx = cnt + ONE;
          end
        end
        MEAS: begin
          if (c2_rise) begin
            period_nx = cnt;
            high_nx   = hi;
            valid_nx  = 1'b1;
            lost_nx   = 1'b0;
            cnt_nx    = ONE;
            hi_nx     = ONE;
          end else if (tmo) begin
            state_nx = ARM;
            lost_nx  = 1'b1;
            cnt_nx   = '0;
            hi_nx    = '0;
          end else begin
            cnt_nx = cnt + ONE;
            hi_nx  = hi + CNT_W'(c2_s2);
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // clear wins over count, but a coincident edge is not lost
  always_comb begin
    rr_nx = rr_count;
    if (rr_count_clr) begin
      rr_nx = (enable && rr_rise) ? ONE : '0;
    end else if (enable && rr_rise && rr_count != SAT) begin
      rr_nx = rr_count + ONE;
    end
  end

endmodule

// File: tb/tb_clk2_monitor.sv
// tb_clk2_monitor: directed test of clk2_monitor measurement,
// loss detection and rr counting with hand-computed results.
module tb_clk2_monitor;

  localparam int W  = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clk2;
  logic          rr;
  logic          rr_count_clr;
  logic [W-1:0]  period;
  logic [W-1:0]  high_time;
  logic          meas_valid;
  logic          lost;
  logic [W-1:0]  rr_count;
  logic [3:0]    period_s;
  logic [3:0]    high_s;
  logic          mv_s;
  logic          lost_s;
  logic [3:0]    rr_count_s;

  int checks = 0;
  int errors = 0;
  int mv_seen = 0;
  int mv_base;

  bit c2_run = 1'b0;
  int c2_per = 8;
  int c2_hi  = 3;
  int c2_ph  = 0;

  clk2_monitor #(
    .CNT_W  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clk2        (clk2),
    .rr          (rr),
    .rr_count_clr(rr_count_clr),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .lost        (lost),
    .rr_count    (rr_count)
  );

  clk2_monitor #(
    .CNT_W  (4),
    .TIMEOUT(10)
  ) dut_s (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clk2        (clk2),
    .rr          (rr),
    .rr_count_clr(rr_count_clr),
    .period      (period_s),
    .high_time   (high_s),
    .meas_valid  (mv_s),
    .lost        (lost_s),
    .rr_count    (rr_count_s)
  );

  always #5 clk = ~clk;

  initial begin
    clk2 = 1'b0;
    forever begin
      @(negedge clk);
      if (c2_run) begin
        clk2  = (c2_ph < c2_hi);
        c2_ph = (c2_ph + 1) % c2_per;
      end else begin
        clk2  = 1'b0;
        c2_ph = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (meas_valid === 1'b1) mv_seen++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_mv(input string tag, input int budget);
    int n = 0;
    while (meas_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, " mv wait"}, 32'(meas_valid), 1);
  endtask

  task automatic rr_pulse(input bit clr);
    rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rr_count_clr = clr;
      if (i == 2) rr_count_clr = 1'b0;
      if (i == 3) rr = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    rr           = 1'b0;
    rr_count_clr = 1'b0;
    c2_run       = 1'b1;
    @(negedge clk);

    // 1: reset hold with toggling inputs, then release disabled
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rr = ~rr;
    end
    check("rst period", 32'(period), 0);
    check("rst high", 32'(high_time), 0);
    check("rst lost", 32'(lost), 0);
    check("rst rr_count", 32'(rr_count), 0);
    check("rst mv", 32'(mv_seen), 0);
    rr  = 1'b0;
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("idle period", 32'(period), 0);
    check("idle high", 32'(high_time), 0);
    check("idle lost", 32'(lost), 0);
    check("idle rr_count", 32'(rr_count), 0);
    check("idle mv", 32'(mv_seen), 0);

    // 2: nominal 8/3
    enable = 1'b1;
    wait_mv("nom1", 40);
    check("nom1 period", 32'(period), 8);
    check("nom1 high", 32'(high_time), 3);
    @(negedge clk);
    check("nom pulse width", 32'(meas_valid), 0);
    repeat (7) @(negedge clk);
    check("nom repeat mv", 32'(meas_valid), 1);
    check("nom2 period", 32'(period), 8);
    check("nom2 high", 32'(high_time), 3);

    // 3: clock loss after a valid measurement
    c2_run = 1'b0;
    mv_base = mv_seen;
    repeat (19) @(negedge clk);
    check("loss lost@19", 32'(lost), 0);
    @(negedge clk);
    check("loss lost@20", 32'(lost), 1);
    check("loss period", 32'(period), 8);
    repeat (30) @(negedge clk);
    check("loss sticky", 32'(lost), 1);
    check("loss no mv", 32'(mv_seen - mv_base), 0);
    c2_run = 1'b1;
    wait_mv("restart", 50);
    check("restart lost", 32'(lost), 0);
    check("restart period", 32'(period), 8);

    // 4: never-started clock
    enable = 1'b0;
    c2_run = 1'b0;
    repeat (10) @(negedge clk);
    mv_base = mv_seen;
    enable = 1'b1;
    repeat (15) @(negedge clk);
    check("nostart lost early", 32'(lost), 0);
    repeat (10) @(negedge clk);
    check("nostart lost", 32'(lost), 1);
    check("nostart no mv", 32'(mv_seen - mv_base), 0);
    enable = 1'b0;
    @(negedge clk);
    check("disable clears lost", 32'(lost), 0);

    // 5: rr counting, clear collision, hold and saturation
    enable = 1'b1;
    for (int i = 0; i < 5; i++) rr_pulse(1'b0);
    check("rr five", 32'(rr_count), 5);
    check("rr five small", 32'(rr_count_s), 5);
    rr_pulse(1'b1);
    check("rr clr+rise", 32'(rr_count), 1);
    check("rr clr+rise small", 32'(rr_count_s), 1);
    enable = 1'b0;
    rr_pulse(1'b0);
    check("rr hold disabled", 32'(rr_count), 1);
    enable = 1'b1;
    rr_count_clr = 1'b1;
    @(negedge clk);
    rr_count_clr = 1'b0;
    check("rr clear", 32'(rr_count), 0);
    for (int i = 0; i < 20; i++) rr_pulse(1'b0);
    check("rr twenty", 32'(rr_count), 20);
    check("rr saturate", 32'(rr_count_s), 15);

    // 6: enable drop mid-measurement, then new 6/2 clock
    c2_run = 1'b1;
    wait_mv("pre-drop", 60);
    check("pre-drop period", 32'(period), 8);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    mv_base = mv_seen;
    c2_per = 6;
    c2_hi  = 2;
    c2_ph  = 0;
    repeat (20) @(negedge clk);
    check("drop no mv", 32'(mv_seen - mv_base), 0);
    check("drop period", 32'(period), 8);
    check("drop high", 32'(high_time), 3);
    check("drop lost", 32'(lost), 0);
    enable = 1'b1;
    wait_mv("fresh", 40);
    check("fresh period", 32'(period), 6);
    check("fresh high", 32'(high_time), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
